// File: rtl/output_bram_reader_if.sv
// Bundle of the BRAM read ports and the output stream of output_bram_reader.
// The master modport is the reader; the slave modport is its BRAM/stream environment.
interface output_bram_reader_if #(
    parameter int DATA_WIDTH                = 32,
    parameter int OUTPUT_BRAM_NUM           = 4,
    parameter int OUTPUT_BRAM_DEPTH         = 1152,
    parameter int OUTPUT_BRAM_ADDRESS_WIDTH = $clog2(OUTPUT_BRAM_DEPTH)
);
    logic                                 i_start;
    logic [OUTPUT_BRAM_ADDRESS_WIDTH:0]   i_word_count;
    logic [0:OUTPUT_BRAM_NUM-1]           o_renable;
    logic [OUTPUT_BRAM_ADDRESS_WIDTH-1:0] o_raddress  [0:OUTPUT_BRAM_NUM-1];
    logic [DATA_WIDTH-1:0]                i_bram_data [0:OUTPUT_BRAM_NUM-1];
    logic [OUTPUT_BRAM_NUM-1:0]           o_output_bram_rst;
    logic [DATA_WIDTH-1:0]                o_data;
    logic                                 o_valid;
    logic                                 i_ready;
    logic                                 o_last;
    logic                                 o_busy;
    logic                                 o_done;

    modport master (
        input  i_start, i_word_count, i_bram_data, i_ready,
        output o_renable, o_raddress, o_output_bram_rst, o_data, o_valid, o_last, o_busy, o_done
    );

    modport slave (
        output i_start, i_word_count, i_bram_data, i_ready,
        input  o_renable, o_raddress, o_output_bram_rst, o_data, o_valid, o_last, o_busy, o_done
    );
endinterface

// File: rtl/output_bram_reader.sv
// Drains OUTPUT_BRAM_NUM banks, bank-interleaved per address, into a ready/valid stream
// through a 4-entry FIFO; read issue is throttled so the FIFO can never overflow.
module output_bram_reader #(
    parameter int DATA_WIDTH                = 32,
    parameter int OUTPUT_BRAM_NUM           = 4,
    parameter int OUTPUT_BRAM_DEPTH         = 1152,
    parameter int OUTPUT_BRAM_ADDRESS_WIDTH = $clog2(OUTPUT_BRAM_DEPTH)
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    output_bram_reader_if.master   bus
);
    localparam int AW = OUTPUT_BRAM_ADDRESS_WIDTH;
    localparam int CW = AW + 1;
    localparam int BW = (OUTPUT_BRAM_NUM > 1) ? $clog2(OUTPUT_BRAM_NUM) : 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   count_reg;
    logic [AW-1:0]   addr;
    logic [BW-1:0]   bank;
    logic            pending;
    logic [BW-1:0]   pend_bank;
    logic            pend_last;
    logic [1:0]      wr_ptr, rd_ptr;
    logic [2:0]      occ;
    logic [2:0]      fill;
    logic [DATA_WIDTH-1:0] fifo_data [0:3];
    logic [3:0]      fifo_last;
    logic            issue, bank_last, addr_last, pop;

    function automatic logic [CW-1:0] sat_count(input logic [CW-1:0] c);
        if (c > CW'(OUTPUT_BRAM_DEPTH))
            return CW'(OUTPUT_BRAM_DEPTH);
        return c;
    endfunction

    // Occupancy plus the read in flight must leave room for the word issued now.
    assign fill      = occ + {2'b00, pending};
    assign issue     = (state == READ) && (fill <= 3'd2);
    assign bank_last = (bank == BW'(OUTPUT_BRAM_NUM - 1));
    assign addr_last = ({1'b0, addr} == (count_reg - CW'(1)));
    assign pop       = bus.o_valid && bus.i_ready;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state     <= IDLE;
            count_reg <= '0;
            addr      <= '0;
            bank      <= '0;
            pending   <= 1'b0;
            pend_bank <= '0;
            pend_last <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && bus.i_start) begin
                count_reg <= sat_count(bus.i_word_count);
                addr      <= '0;
                bank      <= '0;
            end else if (issue) begin
                if (bank_last) begin
                    bank <= '0;
                    if (!addr_last)
                        addr <= addr + AW'(1);
                end else begin
                    bank <= bank + BW'(1);
                end
            end
            pending <= issue;
            if (issue) begin
                pend_bank <= bank;
                pend_last <= bank_last && addr_last;
            end
            if (pending)
                wr_ptr <= wr_ptr + 2'd1;
            if (pop)
                rd_ptr <= rd_ptr + 2'd1;
            occ <= occ + {2'b00, pending} - {2'b00, pop};
        end
    end

    // Capture stage: BRAM data returns one cycle after issue
    always_ff @(posedge i_clock) begin
        if (pending) begin
            fifo_data[wr_ptr] <= bus.i_bram_data[pend_bank];
            fifo_last[wr_ptr] <= pend_last;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.i_start)
                    state_nxt = (sat_count(bus.i_word_count) == '0) ? DONE : READ;
            end
            READ: begin
                if (issue && bank_last && addr_last)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                // Leave as soon as the last buffered word is leaving this cycle.
                if (!pending && (occ == 3'd0 || (occ == 3'd1 && pop)))
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        for (int b = 0; b < OUTPUT_BRAM_NUM; b++) begin
            bus.o_renable[b]  = issue && (bank == BW'(b));
            bus.o_raddress[b] = addr;
        end
    end

    assign bus.o_valid           = (occ != 3'd0);
    assign bus.o_data            = bus.o_valid ? fifo_data[rd_ptr] : '0;
    assign bus.o_last            = bus.o_valid && fifo_last[rd_ptr];
    assign bus.o_busy            = (state == READ) || (state == DRAIN);
    assign bus.o_done            = (state == DONE);
    assign bus.o_output_bram_rst = {OUTPUT_BRAM_NUM{state == DONE}};
endmodule

// File: tb/tb_output_bram_reader.sv
// Directed bench for output_bram_reader: a behavioural BRAM returns a word encoding
// bank and address, and each scenario task compares the stream against hand-derived values.
module tb_output_bram_reader;
    localparam int DW    = 32;
    localparam int NUM   = 4;
    localparam int DEPTH = 1152;
    localparam int AW    = $clog2(DEPTH);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    output_bram_reader_if #(.DATA_WIDTH(DW), .OUTPUT_BRAM_NUM(NUM),
                            .OUTPUT_BRAM_DEPTH(DEPTH), .OUTPUT_BRAM_ADDRESS_WIDTH(AW)) bus ();

    output_bram_reader #(.DATA_WIDTH(DW), .OUTPUT_BRAM_NUM(NUM),
                         .OUTPUT_BRAM_DEPTH(DEPTH), .OUTPUT_BRAM_ADDRESS_WIDTH(AW)) dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    function automatic logic [31:0] pattern(input int b, input int a);
        return 32'hA500_0000 | 32'(b << 12) | 32'(a);
    endfunction

    // One-cycle-latency BRAM model
    always @(posedge clk) begin
        for (int b = 0; b < NUM; b++)
            if (bus.o_renable[b])
                bus.i_bram_data[b] <= pattern(b, int'(bus.o_raddress[b]));
    end

    int errors = 0;
    int checks = 0;

    logic [31:0] words[$];
    bit          lasts[$];
    int          issue_b[$];
    int          issue_a[$];
    int          first_valid, last_xfer, done_cycle, valid_cnt;
    int          onehot_err, addr_err, stable_err, stall_issues, quiet_issues;
    logic        busy_c5;
    logic [NUM-1:0] rst_at_done;
    bit          timeout;

    // Runs one drain from the current cycle and records what the DUT does.
    // mode 0: ready high; 1: ready toggles; 2: ready low for cycles 0..19.
    task automatic run_stream(input int count, input int mode, input int limit);
        logic [31:0] held;
        bit stalled;
        int ones;
        words.delete(); lasts.delete(); issue_b.delete(); issue_a.delete();
        first_valid = -1; last_xfer = -1; done_cycle = -1; valid_cnt = 0;
        onehot_err = 0; addr_err = 0; stable_err = 0; stall_issues = 0; quiet_issues = 0;
        busy_c5 = 1'b0; rst_at_done = '0; timeout = 1'b1; stalled = 1'b0; held = '0;
        bus.i_start      = 1'b1;
        bus.i_word_count = (AW+1)'(count);
        for (int c = 0; c < limit; c++) begin
            if (c > 0) bus.i_start = 1'b0;
            case (mode)
                1:       bus.i_ready = ((c % 2) == 1);
                2:       bus.i_ready = (c >= 20);
                default: bus.i_ready = 1'b1;
            endcase
            #1;
            ones = $countones(bus.o_renable);
            if (ones > 1) onehot_err++;
            for (int b = 0; b < NUM; b++) begin
                if (bus.o_renable[b]) begin
                    issue_b.push_back(b);
                    issue_a.push_back(int'(bus.o_raddress[b]));
                    for (int b2 = 0; b2 < NUM; b2++)
                        if (bus.o_raddress[b2] !== bus.o_raddress[b]) addr_err++;
                    if (mode == 2 && c < 20) stall_issues++;
                    if (mode == 2 && c >= 10 && c < 20) quiet_issues++;
                end
            end
            if (bus.o_valid) begin
                valid_cnt++;
                if (first_valid < 0) first_valid = c;
            end
            if (stalled && bus.o_valid && bus.o_data !== held) stable_err++;
            stalled = 1'b0;
            if (bus.o_valid && bus.i_ready) begin
                words.push_back(bus.o_data);
                lasts.push_back(bus.o_last);
                last_xfer = c;
            end else if (bus.o_valid) begin
                stalled = 1'b1;
                held    = bus.o_data;
            end
            if (c == 5) busy_c5 = bus.o_busy;
            if (bus.o_done) begin
                done_cycle  = c;
                rst_at_done = bus.o_output_bram_rst;
                timeout     = 1'b0;
            end
            @(posedge clk); #1;
            if (done_cycle >= 0) break;
        end
        bus.i_start = 1'b0;
        bus.i_ready = 1'b1;
    endtask

    // Counts words whose data or last flag differs from the bank-interleaved order.
    function automatic int bad_words(input int count);
        int bad = 0;
        for (int k = 0; k < words.size(); k++)
            if (words[k] !== pattern(k % NUM, k / NUM) || lasts[k] != (k == count*NUM - 1))
                bad++;
        return bad;
    endfunction

    task automatic test_reset;
        bus.i_start = 1'b0; bus.i_word_count = '0; bus.i_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({bus.o_valid, bus.o_last, bus.o_busy, bus.o_done} !== 4'b0) begin errors++;
            $display("FAIL reset_flags: got %b expected 0000", {bus.o_valid, bus.o_last, bus.o_busy, bus.o_done}); end
        checks++; if (bus.o_renable !== 4'b0) begin errors++;
            $display("FAIL reset_renable: got %b expected 0000", bus.o_renable); end
        checks++; if (bus.o_output_bram_rst !== 4'b0) begin errors++;
            $display("FAIL reset_bram_rst: got %b expected 0000", bus.o_output_bram_rst); end
        checks++; if (bus.o_data !== 32'h0 || bus.o_raddress[0] !== '0 || bus.o_raddress[3] !== '0) begin errors++;
            $display("FAIL reset_data_addr: got data=%h addr0=%0d expected 0", bus.o_data, bus.o_raddress[0]); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        int bad;
        run_stream(3, 0, 60);
        checks++; if (timeout) begin errors++; $display("FAIL basic_timeout: got no done expected done"); end
        checks++; if (words.size() !== 12) begin errors++;
            $display("FAIL basic_count: got %0d expected 12", words.size()); end
        checks++; if (words.size() > 0 && words[0] !== 32'hA500_0000) begin errors++;
            $display("FAIL basic_word0: got %h expected a5000000", words[0]); end
        checks++; if (words.size() > 11 && words[11] !== 32'hA500_3002) begin errors++;
            $display("FAIL basic_word11: got %h expected a5003002", words[11]); end
        bad = bad_words(3);
        checks++; if (bad !== 0) begin errors++; $display("FAIL basic_order: got %0d bad words expected 0", bad); end
        bad = 0;
        for (int k = 0; k < issue_a.size(); k++)
            if (issue_b[k] != k % NUM || issue_a[k] != k / NUM) bad++;
        checks++; if (bad !== 0 || issue_a.size() !== 12) begin errors++;
            $display("FAIL basic_issue: got %0d issues %0d bad expected 12 issues 0 bad", issue_a.size(), bad); end
        checks++; if (onehot_err !== 0 || addr_err !== 0) begin errors++;
            $display("FAIL basic_renable: got onehot_err=%0d addr_err=%0d expected 0", onehot_err, addr_err); end
        checks++; if (first_valid !== 3) begin errors++;
            $display("FAIL basic_first_valid: got %0d expected 3", first_valid); end
        checks++; if (last_xfer !== 14) begin errors++;
            $display("FAIL basic_last_xfer: got %0d expected 14", last_xfer); end
        checks++; if (done_cycle !== 15) begin errors++;
            $display("FAIL basic_done_cycle: got %0d expected 15", done_cycle); end
        checks++; if (rst_at_done !== 4'b1111) begin errors++;
            $display("FAIL basic_bram_rst: got %b expected 1111", rst_at_done); end
        checks++; if (busy_c5 !== 1'b1) begin errors++;
            $display("FAIL basic_busy: got %b expected 1", busy_c5); end
    endtask

    task automatic test_toggle;
        int bad;
        run_stream(3, 1, 100);
        checks++; if (timeout || words.size() !== 12) begin errors++;
            $display("FAIL toggle_count: got %0d words timeout=%0d expected 12 words", words.size(), timeout); end
        bad = bad_words(3);
        checks++; if (bad !== 0) begin errors++; $display("FAIL toggle_order: got %0d bad words expected 0", bad); end
        checks++; if (stable_err !== 0) begin errors++;
            $display("FAIL toggle_stable: got %0d changes while stalled expected 0", stable_err); end
    endtask

    task automatic test_stall;
        int bad;
        run_stream(3, 2, 120);
        checks++; if (stall_issues > 4 || stall_issues == 0) begin errors++;
            $display("FAIL stall_issues: got %0d expected 1..4", stall_issues); end
        checks++; if (quiet_issues !== 0) begin errors++;
            $display("FAIL stall_quiet: got %0d issues in cycles 10..19 expected 0", quiet_issues); end
        checks++; if (timeout || words.size() !== 12) begin errors++;
            $display("FAIL stall_count: got %0d words timeout=%0d expected 12 words", words.size(), timeout); end
        bad = bad_words(3);
        checks++; if (bad !== 0) begin errors++; $display("FAIL stall_order: got %0d bad words expected 0", bad); end
    endtask

    task automatic test_zero;
        run_stream(0, 0, 20);
        checks++; if (issue_a.size() !== 0 || valid_cnt !== 0) begin errors++;
            $display("FAIL zero_activity: got issues=%0d valid=%0d expected 0", issue_a.size(), valid_cnt); end
        checks++; if (done_cycle !== 1) begin errors++;
            $display("FAIL zero_done_cycle: got %0d expected 1", done_cycle); end
        checks++; if (rst_at_done !== 4'b1111) begin errors++;
            $display("FAIL zero_bram_rst: got %b expected 1111", rst_at_done); end
    endtask

    task automatic test_reset_mid;
        int n = 0;
        bit seen = 1'b0;
        int bad;
        logic zero_addr;
        bus.i_start = 1'b1; bus.i_word_count = (AW+1)'(3); bus.i_ready = 1'b1;
        for (int c = 0; c < 40 && n < 5; c++) begin
            #1;
            if (bus.o_valid && bus.i_ready) n++;
            @(posedge clk); #1;
            bus.i_start = 1'b0;
        end
        checks++; if (n !== 5) begin errors++; $display("FAIL mid_words_before: got %0d expected 5", n); end
        rst_n = 1'b0;
        #1;
        zero_addr = 1'b1;
        for (int b = 0; b < NUM; b++) if (bus.o_raddress[b] !== '0) zero_addr = 1'b0;
        checks++; if ({bus.o_valid, bus.o_last, bus.o_busy, bus.o_done} !== 4'b0 || bus.o_renable !== 4'b0) begin errors++;
            $display("FAIL mid_reset_ctrl: got flags=%b renable=%b expected 0", {bus.o_valid, bus.o_last, bus.o_busy, bus.o_done}, bus.o_renable); end
        checks++; if (bus.o_data !== 32'h0 || !zero_addr || bus.o_output_bram_rst !== 4'b0) begin errors++;
            $display("FAIL mid_reset_data: got data=%h addr_zero=%0d rst=%b expected 0", bus.o_data, zero_addr, bus.o_output_bram_rst); end
        @(posedge clk); #1; @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.o_done || bus.o_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_no_done: got activity expected none"); end
        run_stream(1, 0, 40);
        checks++; if (timeout || words.size() !== 4) begin errors++;
            $display("FAIL mid_restart_count: got %0d words timeout=%0d expected 4", words.size(), timeout); end
        bad = bad_words(1);
        checks++; if (bad !== 0) begin errors++; $display("FAIL mid_restart_order: got %0d bad words expected 0", bad); end
    endtask

    task automatic test_full(input int count, input string tag);
        int bad;
        int last_a;
        run_stream(count, 0, 4700);
        last_a = (issue_a.size() > 0) ? issue_a[issue_a.size()-1] : -1;
        checks++; if (timeout || words.size() !== 4608) begin errors++;
            $display("FAIL %s_count: got %0d words timeout=%0d expected 4608", tag, words.size(), timeout); end
        bad = bad_words(DEPTH);
        checks++; if (bad !== 0) begin errors++; $display("FAIL %s_order: got %0d bad words expected 0", tag, bad); end
        checks++; if (last_a !== 1151 || issue_a.size() !== 4608) begin errors++;
            $display("FAIL %s_last_addr: got %0d (%0d issues) expected 1151 (4608 issues)", tag, last_a, issue_a.size()); end
        checks++; if (last_xfer - first_valid !== 4607) begin errors++;
            $display("FAIL %s_rate: got span %0d expected 4607", tag, last_xfer - first_valid); end
    endtask

    initial begin
        bus.i_start = 1'b0; bus.i_word_count = '0; bus.i_ready = 1'b0;
        test_reset();
        test_basic();
        test_toggle();
        test_stall();
        test_zero();
        test_reset_mid();
        test_full(1152, "full");
        test_full(2000, "saturate");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
